// File: rtl/pq_request_driver.sv
// rtl/pq_request_driver.sv - Command/response front end that serialises accesses to the register-tree priority queue.
module pq_request_driver #(
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [1:0]            o_rsp_status,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data,
  output logic                  o_busy
);

  localparam logic [1:0] OP_PEEK = 2'b00;
  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_REP  = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_EMPTY = 2'b10;
  localparam logic [1:0] ST_ZERO  = 2'b11;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_status;
  logic                  r_rsp_valid;
  logic [7:0]            r_cnt;
  logic                  r_done;

  logic       w_wrt;
  logic       w_read;
  logic [1:0] w_status;
  logic       w_zero_key;
  logic       w_cmd_fire;
  logic       w_rsp_fire;
  logic       w_hs_done;

  assign w_zero_key = (r_data == '0);
  assign w_cmd_fire = i_cmd_valid && (r_state == S_IDLE);
  assign w_rsp_fire = r_rsp_valid && i_rsp_ready;
  assign w_hs_done  = r_done || w_rsp_fire;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes and status are decided purely from the flags seen during the single EXEC cycle.
  always_comb begin
    w_next   = r_state;
    w_wrt    = 1'b0;
    w_read   = 1'b0;
    w_status = ST_OK;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WAIT;
        case (r_op)
          OP_ENQ: begin
            if (w_zero_key)     w_status = ST_ZERO;
            else if (i_pq_full) w_status = ST_FULL;
            else                w_wrt    = 1'b1;
          end
          OP_DEQ: begin
            if (i_pq_empty) w_status = ST_EMPTY;
            else            w_read   = 1'b1;
          end
          OP_REP: begin
            if (w_zero_key) begin
              w_status = ST_ZERO;
            end else begin
              w_wrt  = 1'b1;
              w_read = 1'b1;
            end
          end
          default: begin
            if (i_pq_empty) w_status = ST_EMPTY;
          end
        endcase
      end
      S_WAIT: begin
        if (w_hs_done && (r_cnt == 8'd0)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_op         <= OP_PEEK;
      r_data       <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= ST_OK;
      r_rsp_valid  <= 1'b0;
      r_cnt        <= 8'd0;
      r_done       <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_op   <= i_cmd_op;
        r_data <= i_cmd_data;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data   <= i_pq_data;
        r_rsp_status <= w_status;
        r_rsp_valid  <= 1'b1;
        r_cnt        <= (w_wrt || w_read) ? SETTLE_LOAD : 8'd0;
        r_done       <= 1'b0;
      end else if (r_state == S_WAIT) begin
        // Settle countdown runs regardless of response back-pressure.
        if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        if (w_rsp_fire) r_rsp_valid <= 1'b0;
        if (w_next == S_IDLE) r_done <= 1'b0;
        else if (w_rsp_fire)  r_done <= 1'b1;
      end
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_status = r_rsp_status;
  assign o_pq_wrt     = w_wrt;
  assign o_pq_read    = w_read;
  assign o_pq_data    = (r_state == S_EXEC) ? r_data : '0;

endmodule

// File: tb/tb_pq_request_driver.sv
// tb/tb_pq_request_driver.sv - Directed bench for pq_request_driver against a behavioural 15-entry max-queue.
module tb_pq_request_driver;

  localparam int DW = 16;
  localparam int DEPTH = 15;

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          o_rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic [1:0]    o_rsp_status;
  logic          o_pq_wrt;
  logic          o_pq_read;
  logic [DW-1:0] o_pq_data;
  logic          pq_full;
  logic          pq_empty;
  logic [DW-1:0] pq_root;
  logic          o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  pq_request_driver #(.DATA_WIDTH(DW), .SETTLE_CYCLES(4)) dut (
    .i_CLK(clk), .i_RSTn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_data(cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_status(o_rsp_status),
    .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
    .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_root),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural max-queue: root is the largest stored key, 0 when empty.
  logic [DW-1:0] mem [DEPTH];
  int            qcnt;
  int            maxidx;

  always_comb begin
    pq_root = '0;
    maxidx  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < qcnt && mem[i] > pq_root) begin
        pq_root = mem[i];
        maxidx  = i;
      end
    end
  end
  assign pq_full  = (qcnt == DEPTH);
  assign pq_empty = (qcnt == 0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qcnt <= 0;
    end else if (o_pq_wrt && o_pq_read) begin
      if (qcnt == 0) begin
        mem[0] <= o_pq_data;
        qcnt   <= 1;
      end else begin
        mem[maxidx] <= o_pq_data;
      end
    end else if (o_pq_wrt) begin
      mem[qcnt] <= o_pq_data;
      qcnt      <= qcnt + 1;
    end else if (o_pq_read) begin
      mem[maxidx] <= mem[qcnt-1];
      qcnt        <= qcnt - 1;
    end
  end

  int wrt_n = 0, rd_n = 0, both_n = 0, viol_n = 0, last_wrt = -1;
  always @(negedge clk) begin
    if (o_pq_wrt) begin
      wrt_n    <= wrt_n + 1;
      last_wrt <= cyc;
    end
    if (o_pq_read) rd_n <= rd_n + 1;
    if (o_pq_wrt && o_pq_read) both_n <= both_n + 1;
    if (o_pq_wrt && !o_pq_read && pq_full) viol_n <= viol_n + 1;
  end

  int            g_acc, g_val, g_idle;
  logic [DW-1:0] g_data;
  logic [1:0]    g_stat;

  task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    int n;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!o_cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    g_acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    g_val = -1;
    g_idle = -1;
    g_data = '1;
    g_stat = 2'bxx;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        g_val = cyc;
        g_data = o_rsp_data;
        g_stat = o_rsp_status;
        break;
      end
      n++;
    end
    if (!rsp_ready) return;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        g_idle = cyc;
        break;
      end
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_cmd_ready, o_busy, o_rsp_valid, o_pq_wrt, o_pq_read} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b want 10000", {o_cmd_ready, o_busy, o_rsp_valid, o_pq_wrt, o_pq_read});
    end
    n_cmp++;
    if ({o_rsp_data, o_rsp_status, o_pq_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_data got %h/%b/%h want 0", o_rsp_data, o_rsp_status, o_pq_data);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_enqueue();
    logic [DW-1:0] keys [3];
    logic [DW-1:0] exp  [3];
    int prev_acc;
    keys[0] = 16'd5; keys[1] = 16'd9; keys[2] = 16'd3;
    exp[0]  = 16'd0; exp[1]  = 16'd5; exp[2]  = 16'd9;
    prev_acc = -1;
    for (int i = 0; i < 3; i++) begin
      send_cmd(2'b01, keys[i]);
      n_cmp++;
      if (g_stat !== 2'b00 || g_data !== exp[i]) begin
        n_bad++;
        $display("FAIL enq%0d_rsp got %b/%0d want 00/%0d", i, g_stat, g_data, exp[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (last_wrt !== g_acc + 1 || g_val !== g_acc + 2) begin
          n_bad++;
          $display("FAIL enq_latency got strobe@%0d valid@%0d want %0d/%0d", last_wrt, g_val, g_acc + 1, g_acc + 2);
        end
      end else begin
        n_cmp++;
        if (g_acc - prev_acc !== 7) begin
          n_bad++;
          $display("FAIL enq_spacing got %0d want 7", g_acc - prev_acc);
        end
      end
      prev_acc = g_acc;
    end
    n_cmp++;
    if (g_idle - g_acc !== 7) begin
      n_bad++;
      $display("FAIL enq_idle got %0d want 7", g_idle - g_acc);
    end
  endtask

  task automatic test_dequeue();
    logic [DW-1:0] exp [3];
    int rd0;
    exp[0] = 16'd9; exp[1] = 16'd5; exp[2] = 16'd3;
    for (int i = 0; i < 3; i++) begin
      send_cmd(2'b10, '0);
      n_cmp++;
      if (g_stat !== 2'b00 || g_data !== exp[i]) begin
        n_bad++;
        $display("FAIL deq%0d_rsp got %b/%0d want 00/%0d", i, g_stat, g_data, exp[i]);
      end
    end
    rd0 = rd_n;
    send_cmd(2'b10, '0);
    n_cmp++;
    if (g_stat !== 2'b10 || g_data !== 16'd0 || rd_n !== rd0) begin
      n_bad++;
      $display("FAIL deq_empty got %b/%0d strobes %0d want 10/0 strobes 0", g_stat, g_data, rd_n - rd0);
    end
    n_cmp++;
    if (g_idle - g_acc !== 3) begin
      n_bad++;
      $display("FAIL deq_empty_idle got %0d want 3", g_idle - g_acc);
    end
  endtask

  task automatic test_full_replace();
    int bad_st, w0, r0, b0;
    bad_st = 0;
    for (int k = 1; k <= 15; k++) begin
      send_cmd(2'b01, 16'(k));
      if (g_stat !== 2'b00) bad_st++;
    end
    n_cmp++;
    if (bad_st !== 0 || !pq_full) begin
      n_bad++;
      $display("FAIL fill got %0d bad statuses full=%b want 0/1", bad_st, pq_full);
    end
    w0 = wrt_n;
    send_cmd(2'b01, 16'd7);
    n_cmp++;
    if (g_stat !== 2'b01 || g_data !== 16'd15 || wrt_n !== w0) begin
      n_bad++;
      $display("FAIL enq_full got %b/%0d wrt %0d want 01/15 wrt 0", g_stat, g_data, wrt_n - w0);
    end
    w0 = wrt_n; r0 = rd_n; b0 = both_n;
    send_cmd(2'b11, 16'd7);
    n_cmp++;
    if (g_stat !== 2'b00 || g_data !== 16'd15) begin
      n_bad++;
      $display("FAIL replace_rsp got %b/%0d want 00/15", g_stat, g_data);
    end
    n_cmp++;
    if (wrt_n - w0 !== 1 || rd_n - r0 !== 1 || both_n - b0 !== 1) begin
      n_bad++;
      $display("FAIL replace_strobe got w%0d r%0d b%0d want 1/1/1", wrt_n - w0, rd_n - r0, both_n - b0);
    end
    n_cmp++;
    if (pq_root !== 16'd14) begin
      n_bad++;
      $display("FAIL replace_root got %0d want 14", pq_root);
    end
  endtask

  task automatic test_zero_key();
    logic [1:0] ops [2];
    int w0, r0;
    ops[0] = 2'b01; ops[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      w0 = wrt_n; r0 = rd_n;
      send_cmd(ops[i], 16'd0);
      n_cmp++;
      if (g_stat !== 2'b11 || wrt_n !== w0 || rd_n !== r0) begin
        n_bad++;
        $display("FAIL zero%0d got %b strobes %0d/%0d want 11 0/0", i, g_stat, wrt_n - w0, rd_n - r0);
      end
      n_cmp++;
      if (g_idle - g_acc !== 3) begin
        n_bad++;
        $display("FAIL zero%0d_idle got %0d want 3", i, g_idle - g_acc);
      end
    end
  endtask

  task automatic test_back_pressure();
    int unstable, t_hs, r0;
    rsp_ready = 1'b0;
    r0 = rd_n;
    send_cmd(2'b10, '0);
    n_cmp++;
    if (g_data !== 16'd14 || g_stat !== 2'b00) begin
      n_bad++;
      $display("FAIL bp_rsp got %b/%0d want 00/14", g_stat, g_data);
    end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!o_rsp_valid || !o_busy || o_rsp_data !== g_data || o_rsp_status !== g_stat) unstable++;
    end
    n_cmp++;
    if (unstable !== 0 || rd_n - r0 !== 1) begin
      n_bad++;
      $display("FAIL bp_stable got %0d unstable cycles %0d reads want 0/1", unstable, rd_n - r0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    t_hs = cyc;
    @(negedge clk);
    n_cmp++;
    if (o_cmd_ready !== 1'b0 || o_rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hs_cycle got ready=%b valid=%b want 0/1", o_cmd_ready, o_rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0 || cyc !== t_hs + 1) begin
      n_bad++;
      $display("FAIL bp_idle got ready=%b valid=%b cyc %0d want 1/0 %0d", o_cmd_ready, o_rsp_valid, cyc, t_hs + 1);
    end
  endtask

  task automatic test_reset_mid_op();
    rsp_ready = 1'b0;
    send_cmd(2'b10, '0);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({o_rsp_valid, o_cmd_ready, o_busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL midop_reset got %b want 010", {o_rsp_valid, o_cmd_ready, o_busy});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    send_cmd(2'b00, '0);
    n_cmp++;
    if (g_stat !== 2'b10 || g_data !== 16'd0 || g_idle - g_acc !== 3) begin
      n_bad++;
      $display("FAIL post_reset_peek got %b/%0d idle %0d want 10/0 3", g_stat, g_data, g_idle - g_acc);
    end
    n_cmp++;
    if (viol_n !== 0) begin
      n_bad++;
      $display("FAIL full_write_only got %0d want 0", viol_n);
    end
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_enqueue();
    test_dequeue();
    test_full_replace();
    test_zero_key();
    test_back_pressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
